// File: rtl/freq_meter_ser.sv
// Reciprocal frequency meter: gates sigClk edges against baseClk cycles and streams both counts as a byte frame.
// Define FREQ_FRAME_HDR_EN to wrap the payload in a 0xA5 header and an XOR checksum byte.
module freq_meter_ser #(
  parameter int CNT_W       = 32,
  parameter int GATE_CYCLES = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baseClk,
  input  logic       hard_Clr,
  input  logic       enable,
  input  logic       sigClk,
  output logic [7:0] data,
  output logic       sendEnable,
  input  logic       sendBusy,
  output logic [1:0] Status
);

  localparam int NPAY = 2 * CNT_W / 8;
`ifdef FREQ_FRAME_HDR_EN
  localparam int NFRAME = NPAY + 2;
`else
  localparam int NFRAME = NPAY;
`endif
  localparam int TMO_W = $clog2(GATE_CYCLES + 1);
  localparam int IDX_W = $clog2(NFRAME + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [63:0] GATE_L = 64'(GATE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_GATE, S_LATCH, S_STB, S_HI, S_LO
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 prev_q;
  logic                 se;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [CNT_W-1:0]     base_cnt, sig_cnt;
  logic [CNT_W-1:0]     base_inc, sig_inc;
  logic [2*CNT_W-1:0]   shreg;
  logic [IDX_W-1:0]     byte_idx;
  logic [7:0]           csum_q;
  logic [7:0]           cur_byte;
  logic                 payload_byte;
  logic                 err_q;
  logic                 tmo_done, base_at_max, gate_close, last_byte;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge baseClk or posedge hard_Clr) begin
    if (hard_Clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sigClk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign se          = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign tmo_done    = (tmo_cnt == TMO_W'(GATE_CYCLES - 1));
  assign base_inc    = base_cnt + 1'b1;
  assign sig_inc     = sig_cnt + 1'b1;
  assign base_at_max = (base_inc == CNT_MAX);
  // Gate closes on an edge once the post-increment cycle count reaches the preset.
  assign gate_close  = se && (64'(base_inc) >= GATE_L);
  assign last_byte   = (byte_idx == IDX_W'(NFRAME));

  always_ff @(posedge baseClk or posedge hard_Clr) begin
    if (hard_Clr) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_ARM;
      S_ARM: begin
        if (!enable)       state_d = S_IDLE;
        else if (se)       state_d = S_GATE;
        else if (tmo_done) state_d = S_LATCH;
      end
      S_GATE: begin
        if (!enable)                        state_d = S_IDLE;
        else if (base_at_max || gate_close) state_d = S_LATCH;
      end
      S_LATCH: state_d = S_STB;
      S_STB:   if (!sendBusy) state_d = S_HI;
      S_HI:    if (sendBusy)  state_d = S_LO;
      S_LO: begin
        if (!sendBusy) begin
          if (!last_byte)   state_d = S_STB;
          else if (enable)  state_d = S_ARM;
          else              state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Status = 2'b00;
    case (state_q)
      S_ARM, S_GATE, S_LATCH: Status = 2'b01;
      S_STB, S_HI, S_LO:      Status = {1'b1, err_q};
      default:                Status = 2'b00;
    endcase
  end

  always_comb begin
`ifdef FREQ_FRAME_HDR_EN
    payload_byte = (byte_idx != '0) && (byte_idx != IDX_W'(NFRAME - 1));
    if (byte_idx == '0)                     cur_byte = 8'hA5;
    else if (byte_idx == IDX_W'(NFRAME - 1)) cur_byte = csum_q;
    else                                    cur_byte = shreg[2*CNT_W-1 -: 8];
`else
    payload_byte = 1'b1;
    cur_byte     = shreg[2*CNT_W-1 -: 8];
`endif
  end

  // NOTE: the frame shift register is reset with the rest so a frame can never start from stale counts.
  always_ff @(posedge baseClk or posedge hard_Clr) begin
    if (hard_Clr) begin
      tmo_cnt    <= '0;
      base_cnt   <= '0;
      sig_cnt    <= '0;
      shreg      <= '0;
      byte_idx   <= '0;
      csum_q     <= '0;
      err_q      <= 1'b0;
      data       <= '0;
      sendEnable <= 1'b0;
    end else begin
      sendEnable <= 1'b0;
      case (state_q)
        S_ARM: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (se) begin
            base_cnt <= '0;
            sig_cnt  <= '0;
          end else if (tmo_done) begin
            base_cnt <= '0;
            sig_cnt  <= '0;
            err_q    <= 1'b1;
          end
        end
        S_GATE: begin
          base_cnt <= base_inc;
          if (base_at_max) err_q <= 1'b1;
          if (se && (sig_cnt != CNT_MAX)) begin
            sig_cnt <= sig_inc;
            if (sig_inc == CNT_MAX) err_q <= 1'b1;
          end
        end
        S_LATCH: begin
          shreg    <= {sig_cnt, base_cnt};
          byte_idx <= '0;
          csum_q   <= '0;
        end
        S_STB: begin
          if (!sendBusy) begin
            sendEnable <= 1'b1;
            data       <= cur_byte;
            byte_idx   <= byte_idx + 1'b1;
            if (payload_byte) begin
              shreg  <= {shreg[2*CNT_W-9:0], 8'h00};
              csum_q <= csum_q ^ cur_byte;
            end
          end
        end
        default: ;
      endcase
      // A fresh measurement starts with a clear error flag and timeout.
      if ((state_d == S_ARM) && (state_q != S_ARM)) begin
        err_q   <= 1'b0;
        tmo_cnt <= '0;
      end
    end
  end

endmodule
